regfile_scoreboard: RTL and testbench

- Architectural register file plus per-register busy scoreboard, directly downstream of the writeback stage.
- Consumes wb_regno / wb_data / do_wb from writeback and commits the result.
- Serves two combinational read ports to decode/issue, with same-cycle write bypass.
- Tracks in-flight destinations and raises a hazard that holds issue until the producing instruction retires through writeback.

---
 rtl/regfile_scoreboard.sv | 95 +++++++++
 tb/tb_regfile_scoreboard.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Architectural register file with write-through bypass and a per-register busy
// scoreboard that stalls issue on RAW/WAW hazards until the producer writes back.
module regfile_scoreboard #(
    parameter int unsigned LEN_REGNO = 5,
    parameter int unsigned LEN_REG   = 32,
    parameter bit          ZERO_REG  = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LEN_REGNO-1:0]      rs1_regno,
    input  logic [LEN_REGNO-1:0]      rs2_regno,
    output logic [LEN_REG-1:0]        rs1_data,
    output logic [LEN_REG-1:0]        rs2_data,
    input  logic                      issue_valid,
    input  logic                      issue_uses_rs1,
    input  logic                      issue_uses_rs2,
    input  logic                      issue_is_wb,
    input  logic [LEN_REGNO-1:0]      issue_rd_regno,
    output logic                      issue_ready,
    input  logic [LEN_REGNO-1:0]      wb_regno,
    input  logic [LEN_REG-1:0]        wb_data,
    input  logic                      do_wb,
    output logic [2**LEN_REGNO-1:0]   busy_vec
);

    localparam int unsigned NUM_REGS = 2**LEN_REGNO;

    logic [LEN_REG-1:0]  regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] wb_mask;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] eff_busy;
    logic [NUM_REGS-1:0] busy_next;
    logic                wb_en;
    logic                hazard;
    logic                issue_fire;

    assign wb_en = do_wb & ~(ZERO_REG & (wb_regno == '0));

    // Read ports: hardwired zero, then same-cycle bypass, then stored value
    always_comb begin
        rs1_data = regs[rs1_regno];
        rs2_data = regs[rs2_regno];
        if (do_wb && (wb_regno == rs1_regno)) begin
            rs1_data = wb_data;
        end
        if (do_wb && (wb_regno == rs2_regno)) begin
            rs2_data = wb_data;
        end
        if (ZERO_REG && (rs1_regno == '0)) begin
            rs1_data = '0;
        end
        if (ZERO_REG && (rs2_regno == '0)) begin
            rs2_data = '0;
        end
    end

    // A register retiring this cycle already counts as free
    always_comb begin
        wb_mask  = '0;
        set_mask = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            wb_mask[r]  = do_wb & (wb_regno == LEN_REGNO'(r));
            set_mask[r] = issue_fire & (issue_rd_regno == LEN_REGNO'(r));
        end
        eff_busy  = busy & ~wb_mask;
        busy_next = (busy & ~wb_mask) | set_mask;
    end

    assign hazard = issue_valid &
                    ((issue_uses_rs1 & eff_busy[rs1_regno]) |
                     (issue_uses_rs2 & eff_busy[rs2_regno]) |
                     (issue_is_wb    & eff_busy[issue_rd_regno]));

    assign issue_ready = ~hazard;
    assign issue_fire  = issue_valid & ~hazard & issue_is_wb &
                         ~(ZERO_REG & (issue_rd_regno == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            if (wb_en) begin
                regs[wb_regno] <= wb_data;
            end
            busy <= busy_next;
        end
    end

    assign busy_vec = busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: an array-based reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_regno, rs2_regno;
    logic [31:0] rs1_data, rs2_data;
    logic        issue_valid, issue_uses_rs1, issue_uses_rs2, issue_is_wb;
    logic [4:0]  issue_rd_regno;
    logic        issue_ready;
    logic [4:0]  wb_regno;
    logic [31:0] wb_data;
    logic        do_wb;
    logic [31:0] busy_vec;

    int checks   = 0;
    int failures = 0;
    bit started  = 0;

    logic [31:0] m_reg  [32];
    bit          m_busy [32];

    regfile_scoreboard #(.LEN_REGNO(5), .LEN_REG(32), .ZERO_REG(1'b1)) dut (
        .clk(clk), .rst(rst),
        .rs1_regno(rs1_regno), .rs2_regno(rs2_regno),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .issue_valid(issue_valid), .issue_uses_rs1(issue_uses_rs1),
        .issue_uses_rs2(issue_uses_rs2), .issue_is_wb(issue_is_wb),
        .issue_rd_regno(issue_rd_regno), .issue_ready(issue_ready),
        .wb_regno(wb_regno), .wb_data(wb_data), .do_wb(do_wb),
        .busy_vec(busy_vec)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain arrays following the architectural rules
    function automatic logic [31:0] m_read(input int r);
        if (r == 0) return 32'h0;
        if (do_wb && int'(wb_regno) == r) return wb_data;
        return m_reg[r];
    endfunction

    function automatic bit m_free_busy(input int r);
        return m_busy[r] && !(do_wb && int'(wb_regno) == r);
    endfunction

    function automatic bit m_ready();
        if (!issue_valid) return 1'b1;
        if (issue_uses_rs1 && m_free_busy(int'(rs1_regno))) return 1'b0;
        if (issue_uses_rs2 && m_free_busy(int'(rs2_regno))) return 1'b0;
        if (issue_is_wb && m_free_busy(int'(issue_rd_regno))) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_busy_vec();
        logic [31:0] v;
        v = '0;
        for (int r = 0; r < 32; r++) v[r] = m_busy[r];
        return v;
    endfunction

    always @(posedge clk) begin
        bit fire;
        fire = issue_valid && m_ready() && issue_is_wb && issue_rd_regno != 5'd0;
        for (int r = 0; r < 32; r++) begin
            if (rst) begin
                m_reg[r]  <= '0;
                m_busy[r] <= 1'b0;
            end else begin
                if (do_wb && int'(wb_regno) == r && r != 0) m_reg[r] <= wb_data;
                if (fire && int'(issue_rd_regno) == r) m_busy[r] <= 1'b1;
                else if (do_wb && int'(wb_regno) == r) m_busy[r] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("model_rs1_data", 64'(rs1_data), 64'(m_read(int'(rs1_regno))));
            check("model_rs2_data", 64'(rs2_data), 64'(m_read(int'(rs2_regno))));
            check("model_issue_ready", 64'(issue_ready), 64'(m_ready()));
            check("model_busy_vec", 64'(busy_vec), 64'(m_busy_vec()));
        end
    end

    task automatic idle();
        rs1_regno = '0; rs2_regno = '0;
        issue_valid = 0; issue_uses_rs1 = 0; issue_uses_rs2 = 0; issue_is_wb = 0;
        issue_rd_regno = '0; wb_regno = '0; wb_data = '0; do_wb = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic issue(input logic [4:0] rd, input bit is_wb,
                         input bit u1, input logic [4:0] r1,
                         input bit u2, input logic [4:0] r2);
        issue_valid = 1; issue_is_wb = is_wb; issue_rd_regno = rd;
        issue_uses_rs1 = u1; rs1_regno = r1;
        issue_uses_rs2 = u2; rs2_regno = r2;
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        do_wb = 1; wb_regno = r; wb_data = d;
    endtask

    initial begin
        idle();
        rst = 1;
        step(); step();
        rst = 0;
        started = 1;
        // Reset state
        rs1_regno = 5'd3; rs2_regno = 5'd0;
        @(negedge clk);
        check("reset_rs1", 64'(rs1_data), 64'h0);
        check("reset_rs2", 64'(rs2_data), 64'h0);
        check("reset_ready", 64'(issue_ready), 64'h1);
        check("reset_busy", 64'(busy_vec), 64'h0);

        // Write-through bypass then stored read
        step(); wb(5'd5, 32'hDEADBEEF); rs1_regno = 5'd5;
        @(negedge clk); check("bypass_rs1", 64'(rs1_data), 64'hDEADBEEF);
        step(); rs1_regno = 5'd5;
        @(negedge clk); check("stored_rs1", 64'(rs1_data), 64'hDEADBEEF);

        // RAW on reg 7 released by same-cycle writeback
        step(); issue(5'd7, 1, 0, 5'd0, 0, 5'd0);
        @(negedge clk); check("issue7_ready", 64'(issue_ready), 64'h1);
        step(); issue(5'd0, 0, 0, 5'd0, 1, 5'd7);
        @(negedge clk);
        check("raw7_stall", 64'(issue_ready), 64'h0);
        check("busy7_set", 64'(busy_vec[7]), 64'h1);
        step(); issue(5'd0, 0, 0, 5'd0, 1, 5'd7); wb(5'd7, 32'h12);
        @(negedge clk);
        check("raw7_release", 64'(issue_ready), 64'h1);
        check("raw7_bypass", 64'(rs2_data), 64'h12);
        step();
        @(negedge clk); check("busy7_clear", 64'(busy_vec[7]), 64'h0);

        // Simultaneous writeback and new producer on reg 9
        step(); issue(5'd9, 1, 0, 5'd0, 0, 5'd0); wb(5'd9, 32'h99);
        @(negedge clk); check("r9_ready", 64'(issue_ready), 64'h1);
        step(); rs1_regno = 5'd9;
        @(negedge clk);
        check("r9_busy", 64'(busy_vec[9]), 64'h1);
        check("r9_data", 64'(rs1_data), 64'h99);
        step(); issue(5'd9, 1, 0, 5'd0, 0, 5'd0); wb(5'd9, 32'h9A);
        @(negedge clk); check("r9_reissue_ready", 64'(issue_ready), 64'h1);
        step(); rs1_regno = 5'd9;
        @(negedge clk);
        check("r9_still_busy", 64'(busy_vec[9]), 64'h1);
        check("r9_data2", 64'(rs1_data), 64'h9A);

        // Register 0 hardwired
        step(); wb(5'd0, 32'hFF); rs1_regno = 5'd0;
        @(negedge clk); check("r0_bypass_zero", 64'(rs1_data), 64'h0);
        step(); issue(5'd0, 1, 1, 5'd0, 0, 5'd0);
        @(negedge clk);
        check("r0_ready", 64'(issue_ready), 64'h1);
        check("r0_read", 64'(rs1_data), 64'h0);
        step();
        @(negedge clk); check("r0_not_busy", 64'(busy_vec[0]), 64'h0);

        // Busy 2 and 4, then reset during a writeback
        step(); issue(5'd2, 1, 0, 5'd0, 0, 5'd0);
        step(); issue(5'd4, 1, 0, 5'd0, 0, 5'd0);
        step();
        @(negedge clk); check("busy_2_4_9", 64'(busy_vec), 64'h214);
        step(); rst = 1; wb(5'd2, 32'hAB);
        step(); rst = 0; issue(5'd0, 0, 1, 5'd2, 1, 5'd5);
        @(negedge clk);
        check("postrst_rs1", 64'(rs1_data), 64'h0);
        check("postrst_rs2", 64'(rs2_data), 64'h0);
        check("postrst_ready", 64'(issue_ready), 64'h1);
        check("postrst_busy", 64'(busy_vec), 64'h0);

        // Unscoreboarded write, WAW stall, blocked issue must not set busy
        step(); wb(5'd4, 32'h44); rs1_regno = 5'd4;
        @(negedge clk); check("plain_wb_bypass", 64'(rs1_data), 64'h44);
        step(); rs1_regno = 5'd4;
        @(negedge clk);
        check("plain_wb_data", 64'(rs1_data), 64'h44);
        check("plain_wb_busy", 64'(busy_vec), 64'h0);
        step(); issue(5'd3, 1, 0, 5'd0, 0, 5'd0);
        step(); issue(5'd3, 1, 0, 5'd0, 0, 5'd0);
        @(negedge clk); check("waw_stall", 64'(issue_ready), 64'h0);
        step(); issue(5'd11, 1, 1, 5'd3, 0, 5'd0);
        @(negedge clk); check("raw_rs1_stall", 64'(issue_ready), 64'h0);
        step(); issue_uses_rs1 = 1; rs1_regno = 5'd3;
        @(negedge clk); check("no_valid_ready", 64'(issue_ready), 64'h1);
        step();
        @(negedge clk); check("blocked_no_set", 64'(busy_vec), 64'h8);

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
